data_ram_bytelane: RTL and testbench

- Synchronous RV32 data memory for the load/store path; successor to the single-width word RAM.
- Parametrised depth and base address; byte-lane writes and sign/zero-extended loads per funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Registered read data with a valid strobe and a registered fault code.
- Sits between the execute stage's address adder and the writeback mux.

---
 rtl/ram_pkg.sv | 26 ++
 rtl/load_align.sv | 29 ++
 rtl/data_ram_bytelane.sv | 115 +++++++++++
 tb/tb_data_ram_bytelane.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared funct3 codes, fault encoding and byte-enable helper for the data RAM
package ram_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FLT_OK       = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10,
        FLT_ILLEGAL  = 2'b11
    } fault_t;

    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B:    byte_mask = 4'b0001 << lane;
            F3_H:    byte_mask = 4'b0011 << {lane[1], 1'b0};
            F3_W:    byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and sign/zero-extends a byte, half or word from a 32-bit word
module load_align
    import ram_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(word >> {lane, 3'b000});
    assign half_v = 16'(word >> {lane[1], 4'b0000});

    always_comb begin
        result = '0;
        case (funct3)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_BU:   result = {24'h0, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_HU:   result = {16'h0, half_v};
            F3_W:    result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_ram_bytelane.sv
// rtl/data_ram_bytelane.sv - RV32 data memory with byte-lane stores and registered extended loads
module data_ram_bytelane
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ramR,
    input  logic        ramW,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] dataW,
    output logic [31:0] dataR,
    output logic        rvalid,
    output logic [1:0]  fault
);

    // 33-bit limit so a base near the top of the address space cannot wrap
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] index;
    logic [1:0]       lane;
    logic             in_range, legal, misaligned;
    fault_t           fault_c;
    logic [3:0]       we_mask;
    logic [31:0]      wdata;

    logic [31:0] rd_word;
    logic [2:0]  rd_f3;
    logic [1:0]  rd_lane;
    logic        rd_ok;
    fault_t      fault_q;
    logic [31:0] aligned;

    assign index    = IDX_W'((addr - BASE_ADDR) >> 2);
    assign lane     = addr[1:0];
    assign in_range = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);

    always_comb begin
        legal = 1'b0;
        if (ramR)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        else if (ramW)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end

    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        fault_c = FLT_OK;
        if (ramR || ramW) begin
            if ((ramR && ramW) || !legal) fault_c = FLT_ILLEGAL;
            else if (!in_range)          fault_c = FLT_RANGE;
            else if (misaligned)         fault_c = FLT_MISALIGN;
        end
    end

    assign we_mask = (!reset && ramW && !ramR && fault_c == FLT_OK) ? byte_mask(funct3, lane) : 4'b0000;

    always_comb begin
        wdata = dataW;
        case (funct3)
            F3_B:    wdata = {4{dataW[7:0]}};
            F3_H:    wdata = {2{dataW[15:0]}};
            default: wdata = dataW;
        endcase
    end

    // Contents survive reset; only the enables are gated by it
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++)
            if (we_mask[b])
                mem[index][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_word <= '0;
            rd_f3   <= F3_W;
            rd_lane <= 2'b00;
            rd_ok   <= 1'b0;
            rvalid  <= 1'b0;
            fault_q <= FLT_OK;
        end else begin
            rvalid  <= ramR && !ramW;
            fault_q <= fault_c;
            if (ramR && !ramW) begin
                rd_word <= mem[index];
                rd_f3   <= funct3;
                rd_lane <= lane;
                rd_ok   <= (fault_c == FLT_OK);
            end else if (ramR) begin
                rvalid  <= 1'b1;
                rd_ok   <= 1'b0;
            end
        end
    end

    load_align u_align (
        .word   (rd_word),
        .funct3 (rd_f3),
        .lane   (rd_lane),
        .result (aligned)
    );

    assign dataR = rd_ok ? aligned : 32'h0;
    assign fault = fault_q;

endmodule

// File: tb/tb_data_ram_bytelane.sv
// tb/tb_data_ram_bytelane.sv - self-checking bench for data_ram_bytelane against a byte-array model
module tb_data_ram_bytelane;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ramR = 1'b0, ramW = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0, dataW = 32'h0;
    logic [31:0] dataR;
    logic        rvalid;
    logic [1:0]  fault;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  ref_mem [256];
    logic [31:0] exp_data = 32'h0;

    always #5 clock = ~clock;

    data_ram_bytelane dut (
        .clock  (clock),
        .reset  (reset),
        .ramR   (ramR),
        .ramW   (ramW),
        .funct3 (funct3),
        .addr   (addr),
        .dataW  (dataW),
        .dataR  (dataR),
        .rvalid (rvalid),
        .fault  (fault)
    );

    function automatic int access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] model_fault(input logic r, input logic w, input logic [2:0] f3,
                                               input logic [31:0] a);
        logic ok_code;
        if (!r && !w) return 2'b00;
        if (r) ok_code = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else   ok_code = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        if ((r && w) || !ok_code) return 2'b11;
        if (a < 32'h100 || a >= 32'h200) return 2'b10;
        if ((a % access_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int sz, off;
        sz  = access_size(f3);
        off = int'(a - 32'h100);
        v   = 32'h0;
        for (int i = 0; i < sz; i++)
            v = v + (32'(ref_mem[off + i]) << (8 * i));
        if (sz < 4 && !f3[2] && v[8*sz-1])
            v = v - (32'h1 << (8 * sz));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [1:0] ef;
        logic       ev;
        ramR = r; ramW = w; funct3 = f3; addr = a; dataW = d;
        if (reset) begin
            ef = 2'b00; ev = 1'b0; exp_data = 32'h0;
        end else begin
            ef = model_fault(r, w, f3, a);
            ev = r;
            if (r) exp_data = (ef == 2'b00) ? model_load(f3, a) : 32'h0;
            if (w && !r && ef == 2'b00)
                for (int i = 0; i < access_size(f3); i++)
                    ref_mem[int'(a - 32'h100) + i] = 8'((d >> (8 * i)) & 32'hFF);
        end
        @(posedge clock);
        #1;
        check({tag, ".fault"}, 32'(fault), 32'(ef));
        check({tag, ".rvalid"}, 32'(rvalid), 32'(ev));
        check({tag, ".dataR"}, dataR, exp_data);
        ramR = 1'b0; ramW = 1'b0;
    endtask

    task automatic idle(input string tag);
        do_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, tag);
    endtask

    initial begin
        do_op(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, "rst0");
        reset = 1'b0;

        for (int i = 0; i < 64; i++)
            do_op(1'b0, 1'b1, 3'b010, 32'h100 + 32'(4 * i), $urandom, "init");

        do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hCAFEF00D, "pre_sw");
        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "pre_lw");
        reset = 1'b1;
        do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'h12345678, "rst_sw1");
        do_op(1'b1, 1'b1, 3'b010, 32'h100, 32'h12345678, "rst_sw2");
        check("rst.dataR0", dataR, 32'h0);
        reset = 1'b0;
        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "rst_lw");
        check("rst.kept", dataR, 32'hCAFEF00D);

        do_op(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, "sw104");
        do_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, "lw104");
        check("lw104.const", dataR, 32'hDEADBEEF);
        idle("hold");
        check("hold.dataR", dataR, 32'hDEADBEEF);
        do_op(1'b1, 1'b0, 3'b000, 32'h107, 32'h0, "lb107");
        check("lb107.const", dataR, 32'hFFFFFFDE);
        do_op(1'b1, 1'b0, 3'b100, 32'h107, 32'h0, "lbu107");
        check("lbu107.const", dataR, 32'h000000DE);
        do_op(1'b1, 1'b0, 3'b001, 32'h106, 32'h0, "lh106");
        check("lh106.const", dataR, 32'hFFFFDEAD);
        do_op(1'b1, 1'b0, 3'b101, 32'h104, 32'h0, "lhu104");
        check("lhu104.const", dataR, 32'h0000BEEF);
        do_op(1'b1, 1'b0, 3'b000, 32'h104, 32'h0, "lb104");
        check("lb104.const", dataR, 32'hFFFFFFEF);

        do_op(1'b0, 1'b1, 3'b000, 32'h105, 32'hFFFFFF55, "sb105");
        do_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, "lw_sb");
        check("sb.const", dataR, 32'hDEAD55EF);
        do_op(1'b0, 1'b1, 3'b001, 32'h106, 32'h1234A5A5, "sh106");
        do_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, "lw_sh");
        check("sh.const", dataR, 32'hA5A555EF);

        do_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, "lw_mis");
        check("mis.const", 32'(fault), 32'h1);
        do_op(1'b0, 1'b1, 3'b010, 32'h200, 32'h11111111, "sw_range");
        check("range.const", 32'(fault), 32'h2);
        do_op(1'b1, 1'b1, 3'b010, 32'h104, 32'h22222222, "rw_both");
        check("both.const", 32'(fault), 32'h3);
        do_op(1'b1, 1'b0, 3'b011, 32'h104, 32'h0, "lw_f3_011");
        do_op(1'b0, 1'b1, 3'b100, 32'h104, 32'h33333333, "sw_f3_100");
        do_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, "lw_after_faults");
        check("nochange.const", dataR, 32'hA5A555EF);
        do_op(1'b1, 1'b0, 3'b010, 32'hFC, 32'h0, "lw_below");
        do_op(1'b1, 1'b0, 3'b010, 32'h1FC, 32'h0, "lw_top");
        do_op(1'b1, 1'b0, 3'b001, 32'h1FF, 32'h0, "lh_top_mis");

        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "stream0");
        do_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, "stream1");
        do_op(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, "stream2");
        do_op(1'b0, 1'b1, 3'b010, 32'h10C, 32'h0BADC0DE, "raw_sw");
        do_op(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, "raw_lw");
        check("raw.const", dataR, 32'h0BADC0DE);
        idle("idle_end");

        for (int k = 0; k < 400; k++) begin
            logic r, w;
            int sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 19));
            r = (sel < 9) || (sel == 19);
            w = (sel >= 9 && sel < 17) || (sel == 19);
            a = 32'h0F0 + 32'($urandom_range(0, 287));
            if ($urandom_range(0, 1) == 1) a = {a[31:2], 2'b00};
            do_op(r, w, 3'($urandom_range(0, 7)), a, $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
